// File: rtl/led_frame_sched.sv
// LED frame scheduler: snapshots per-channel RGB means, streams them to a FIFO,
// kicks the serializer and waits for completion. `LED_SCHED_FRMCNT_EN adds frame_cnt.
module led_frame_sched #(
    parameter int NCH   = 8,
    parameter int CW    = 4,
    parameter int TX_TO = 4096
) (
    input  logic              clk_slow,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [NCH*CW-1:0] MeanR,
    input  logic [NCH*CW-1:0] MeanG,
    input  logic [NCH*CW-1:0] MeanB,
    input  logic              fifo_full,
    input  logic              tx_done,
    input  logic              err_clr,
    output logic              we,
    output logic [3*CW-1:0]   fifo_data_in,
    output logic              send_start,
    output logic              busy,
    output logic              frame_done,
    output logic              ovr_err,
    output logic              to_err
`ifdef LED_SCHED_FRMCNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, KICK, WAIT_TX} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [NCH*CW-1:0] shr_q, shg_q, shb_q;
    logic              ovr_q, ovr_d;
    logic              to_q, to_d;
    logic              snap;
    logic              ovr_set, to_set;

    logic [CW-1:0] shr_ch [NCH];
    logic [CW-1:0] shg_ch [NCH];
    logic [CW-1:0] shb_ch [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign shr_ch[k] = shr_q[CW*k +: CW];
        assign shg_ch[k] = shg_q[CW*k +: CW];
        assign shb_ch[k] = shb_q[CW*k +: CW];
    end

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            shr_q   <= '0;
            shg_q   <= '0;
            shb_q   <= '0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
            // Shadow copy decouples the frame in flight from live mean updates
            if (snap) begin
                shr_q <= MeanR;
                shg_q <= MeanG;
                shb_q <= MeanB;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = '0;
        snap         = 1'b0;
        we           = 1'b0;
        send_start   = 1'b0;
        frame_done   = 1'b0;
        fifo_data_in = '0;
        to_set       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && en) begin
                    snap    = 1'b1;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                fifo_data_in = {shr_ch[idx_q], shg_ch[idx_q], shb_ch[idx_q]};
                we           = !fifo_full;
                if (we) begin
                    if (idx_q == IW'(NCH - 1)) begin
                        idx_d   = '0;
                        state_d = KICK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            KICK: begin
                send_start = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                // Completion is checked first so a tx_done on the last cycle beats the timeout
                if (tx_done) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end else if (tmo_q == 16'(TX_TO - 1)) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        ovr_set = start && (state_q != IDLE);
        ovr_d   = ovr_set || (ovr_q && !err_clr);
        to_d    = to_set  || (to_q  && !err_clr);

        // Outputs are silenced for the whole reset cycle, not only after the edge
        if (rst) begin
            we           = 1'b0;
            send_start   = 1'b0;
            frame_done   = 1'b0;
            fifo_data_in = '0;
        end
    end

    assign busy    = (state_q != IDLE) && !rst;
    assign ovr_err = ovr_q && !rst;
    assign to_err  = to_q && !rst;

`ifdef LED_SCHED_FRMCNT_EN
    logic [15:0] frm_cnt_q;

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            frm_cnt_q <= '0;
        end else if (frame_done) begin
            frm_cnt_q <= frm_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frm_cnt_q;
`endif

endmodule
